verdict_serializer: RTL

- Sits directly downstream of the generated monitor top entity and consumes its per-cycle output bundle: NUM_OUT signed values, each with an aktv flag.
- Timestamps every cycle in which any output is active, buffers that verdict in a small FIFO, and drains it as a stream of (index, value, timestamp) beats over a valid/ready handshake.
- Gives host logic or a UART bridge a narrow, back-pressurable view of monitor verdicts.

---
 rtl/verdict_serializer_pkg.sv | 28 ++
 rtl/verdict_fifo.sv | 58 +++++
 rtl/verdict_serializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/verdict_serializer_pkg.sv
// Shared types and constants for the monitor verdict serializer.
//   verdict_t        : one buffered verdict (timestamp, active mask, all stream values)
//   lowest_set_index : priority encoder choosing the next stream to emit
package verdict_serializer_pkg;

  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TS_W    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned IDX_W   = $clog2(NUM_OUT);

  typedef struct packed {
    logic [TS_W-1:0]                ts;
    logic [NUM_OUT-1:0]             aktv;
    logic [NUM_OUT-1:0][DATA_W-1:0] data;
  } verdict_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [NUM_OUT-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Synchronous show-ahead FIFO of whole verdicts.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full or when a pop happens at the same edge
//   pop, dout  : read request; dout always presents the head entry
//   empty, full: occupancy flags
module verdict_fifo
  import verdict_serializer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  verdict_t din,
  output verdict_t dout,
  output logic     empty,
  output logic     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  verdict_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves at the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/verdict_serializer.sv
// Timestamps active monitor verdicts, buffers them and streams them out one
// active stream per beat over a valid/ready handshake.
//   clk, rst          : clock, synchronous active-high reset
//   en                : monitor enable; gates capture and the timestamp counter
//   out_data/out_aktv : monitor output bundle (stream i at [i*DATA_W +: DATA_W])
//   m_*               : beat stream (index, value, timestamp, last-of-verdict)
//   fifo_full         : buffer at capacity
//   overflow/drop_cnt : sticky drop flag and saturating drop counter
module verdict_serializer
  import verdict_serializer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          m_index,
  output logic [DATA_W-1:0]         m_value,
  output logic [TS_W-1:0]           m_ts,
  output logic                      m_last,
  output logic                      fifo_full,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [TS_W-1:0]  ts;
  verdict_t         work;
  verdict_t         nxt_work;
  verdict_t         fifo_din;
  verdict_t         fifo_dout;
  logic             fifo_empty;
  logic             capture;
  logic             push;
  logic             pop;
  logic             beat_done;
  logic             nxt_valid;
  logic [IDX_W-1:0] nxt_index;

  assign capture   = en && (out_aktv != '0);
  assign beat_done = m_valid && m_ready;
  // Load the working register when idle, or right after the last beat so verdicts run back to back.
  assign pop       = !fifo_empty && ((state == IDLE) || (beat_done && m_last));
  assign push      = capture && (!fifo_full || pop);

  // Verdict as written into the FIFO: timestamp before this edge's increment.
  always_comb begin
    fifo_din      = '0;
    fifo_din.ts   = ts;
    fifo_din.aktv = out_aktv;
    fifo_din.data = out_data;
  end

  verdict_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next working register content; drives the registered beat outputs.
  always_comb begin
    nxt_work  = work;
    nxt_valid = (state == EMIT);
    if (pop) begin
      nxt_work  = fifo_dout;
      nxt_valid = 1'b1;
    end else if (beat_done) begin
      nxt_work.aktv = work.aktv & (work.aktv - 1'b1);
      nxt_valid     = !m_last;
    end
    nxt_index = lowest_set_index(nxt_work.aktv);
  end

  // FSM, timestamp counter, drop accounting and registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ts       <= '0;
      work     <= '0;
      m_valid  <= 1'b0;
      m_index  <= '0;
      m_value  <= '0;
      m_ts     <= '0;
      m_last   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en) ts <= ts + 1'b1;

      if (capture && !push) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end

      case (state)
        IDLE:    if (pop) state <= EMIT;
        EMIT:    if (beat_done && m_last && !pop) state <= IDLE;
        default: state <= IDLE;
      endcase

      work    <= nxt_work;
      m_valid <= nxt_valid;
      if (nxt_valid) begin
        m_index <= nxt_index;
        m_value <= nxt_work.data[nxt_index];
        m_ts    <= nxt_work.ts;
        m_last  <= $onehot(nxt_work.aktv);
      end else begin
        m_index <= '0;
        m_value <= '0;
        m_ts    <= '0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
